watch_core: RTL and testbench

Parametrised BCD time-of-day counter. It is the successor of the cascaded-counter watch and adds the following:
- an internal seconds prescaler;
- a selectable 12/24-hour mode with an AM/PM flag;
- a validated parallel time load;
- a single-cycle day-rollover pulse.

It sits under the watch controller. It drives the display digit outputs and feeds daypass to the date/alarm logic.

---
 rtl/watch_core_if.sv | 25 ++
 rtl/watch_core.sv | 127 ++++++++++++
 tb/tb_watch_core.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/watch_core_if.sv
// rtl/watch_core_if.sv - control, load and display signals of the BCD time-of-day counter
interface watch_core_if;
  logic       start_resume;
  logic       stop;
  logic       set_time;
  logic [3:0] in_hr1, in_hr0, in_min1, in_min0, in_sec1, in_sec0;
  logic       in_pm;
  logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
  logic       pm;
  logic       daypass;
  logic       running;
  logic       set_err;

  modport master (
    output start_resume, stop, set_time,
    output in_hr1, in_hr0, in_min1, in_min0, in_sec1, in_sec0, in_pm,
    input  hr1, hr0, min1, min0, sec1, sec0, pm, daypass, running, set_err
  );

  modport slave (
    input  start_resume, stop, set_time,
    input  in_hr1, in_hr0, in_min1, in_min0, in_sec1, in_sec0, in_pm,
    output hr1, hr0, min1, min0, sec1, sec0, pm, daypass, running, set_err
  );
endinterface

// File: rtl/watch_core.sv
// rtl/watch_core.sv - BCD time-of-day counter with prescaler, 12/24h mode and validated load
module watch_core #(
  parameter int CLK_DIV   = 1,
  parameter int HOUR_MODE = 24,
  parameter int CNT_W     = 26
) (
  input logic         clk,
  input logic         reset,
  watch_core_if.slave w
);
  if (HOUR_MODE != 12 && HOUR_MODE != 24) begin : g_bad_mode
    $error("watch_core: HOUR_MODE must be 12 or 24");
  end
  if (CLK_DIV < 1 || (CNT_W < 32 && (64'(1) << CNT_W) < 64'(CLK_DIV))) begin : g_bad_div
    $error("watch_core: CLK_DIV out of range for CNT_W");
  end

  localparam bit               MODE12 = (HOUR_MODE == 12);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       RST_H1 = MODE12 ? 4'd1 : 4'd0;
  localparam logic [3:0]       RST_H0 = MODE12 ? 4'd2 : 4'd0;

  logic [CNT_W-1:0] cnt;
  logic [3:0] hr1, hr0, min1, min0, sec1, sec0;
  logic       pm, daypass, running, set_err;

  logic       tick, load_ok, day_wrap;
  logic       c_sec1, c_min0, c_min1, c_hr;
  logic [3:0] n_hr1, n_hr0, n_min1, n_min0, n_sec1, n_sec0;
  logic       n_pm;

  assign tick = running && (cnt == LAST);

  always_comb begin
    load_ok = (w.in_sec0 <= 4'd9) && (w.in_sec1 <= 4'd5) &&
              (w.in_min0 <= 4'd9) && (w.in_min1 <= 4'd5);
    if (MODE12)
      load_ok = load_ok && (((w.in_hr1 == 4'd0) && (w.in_hr0 != 4'd0) && (w.in_hr0 <= 4'd9)) ||
                            ((w.in_hr1 == 4'd1) && (w.in_hr0 <= 4'd2)));
    else
      load_ok = load_ok && (((w.in_hr1 <= 4'd1) && (w.in_hr0 <= 4'd9)) ||
                            ((w.in_hr1 == 4'd2) && (w.in_hr0 <= 4'd3)));
  end

  // Ripple carry through the digits; each stage only moves when all lower stages wrap.
  always_comb begin
    c_sec1   = (sec0 == 4'd9);
    c_min0   = c_sec1 && (sec1 == 4'd5);
    c_min1   = c_min0 && (min0 == 4'd9);
    c_hr     = c_min1 && (min1 == 4'd5);
    n_sec0   = c_sec1 ? 4'd0 : sec0 + 4'd1;
    n_sec1   = sec1;
    n_min0   = min0;
    n_min1   = min1;
    n_hr1    = hr1;
    n_hr0    = hr0;
    n_pm     = pm;
    day_wrap = 1'b0;
    if (c_sec1) n_sec1 = (sec1 == 4'd5) ? 4'd0 : sec1 + 4'd1;
    if (c_min0) n_min0 = (min0 == 4'd9) ? 4'd0 : min0 + 4'd1;
    if (c_min1) n_min1 = (min1 == 4'd5) ? 4'd0 : min1 + 4'd1;
    if (c_hr) begin
      if (MODE12 && hr1 == 4'd1 && hr0 == 4'd2) begin
        n_hr1 = 4'd0;
        n_hr0 = 4'd1;
      end else if (MODE12 && hr1 == 4'd1 && hr0 == 4'd1) begin
        n_hr0    = 4'd2;
        n_pm     = ~pm;
        day_wrap = pm;
      end else if (!MODE12 && hr1 == 4'd2 && hr0 == 4'd3) begin
        n_hr1    = 4'd0;
        n_hr0    = 4'd0;
        day_wrap = 1'b1;
      end else if (hr0 == 4'd9) begin
        n_hr1 = hr1 + 4'd1;
        n_hr0 = 4'd0;
      end else begin
        n_hr0 = hr0 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      {hr1, hr0}   <= {RST_H1, RST_H0};
      {min1, min0} <= 8'h00;
      {sec1, sec0} <= 8'h00;
      pm           <= 1'b0;
      cnt          <= '0;
      running      <= 1'b0;
      daypass      <= 1'b0;
      set_err      <= 1'b0;
    end else begin
      if (w.stop)              running <= 1'b0;
      else if (w.start_resume) running <= 1'b1;

      if (w.set_time && load_ok) begin
        // A valid load wins over a coincident tick and restarts the second.
        {hr1, hr0, min1, min0, sec1, sec0} <=
          {w.in_hr1, w.in_hr0, w.in_min1, w.in_min0, w.in_sec1, w.in_sec0};
        pm      <= MODE12 ? w.in_pm : 1'b0;
        cnt     <= '0;
        daypass <= 1'b0;
        set_err <= 1'b0;
      end else begin
        if (w.set_time) set_err <= 1'b1;
        daypass <= tick && day_wrap;
        if (running) cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          {hr1, hr0, min1, min0, sec1, sec0} <= {n_hr1, n_hr0, n_min1, n_min0, n_sec1, n_sec0};
          pm <= MODE12 ? n_pm : 1'b0;
        end
      end
    end
  end

  assign w.hr1     = hr1;
  assign w.hr0     = hr0;
  assign w.min1    = min1;
  assign w.min0    = min0;
  assign w.sec1    = sec1;
  assign w.sec0    = sec0;
  assign w.pm      = pm;
  assign w.daypass = daypass;
  assign w.running = running;
  assign w.set_err = set_err;
endmodule

// File: tb/tb_watch_core.sv
// tb/tb_watch_core.sv - directed bench over three watch_core configurations
module tb_watch_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  watch_core_if ia ();
  watch_core_if ib ();
  watch_core_if ic ();

  watch_core #(.CLK_DIV(4), .HOUR_MODE(24), .CNT_W(26)) u_a (.clk(clk), .reset(reset), .w(ia));
  watch_core #(.CLK_DIV(1), .HOUR_MODE(24), .CNT_W(26)) u_b (.clk(clk), .reset(reset), .w(ib));
  watch_core #(.CLK_DIV(1), .HOUR_MODE(12), .CNT_W(26)) u_c (.clk(clk), .reset(reset), .w(ic));

  logic [23:0] t_a, t_b, t_c;
  assign t_a = {ia.hr1, ia.hr0, ia.min1, ia.min0, ia.sec1, ia.sec0};
  assign t_b = {ib.hr1, ib.hr0, ib.min1, ib.min0, ib.sec1, ib.sec0};
  assign t_c = {ic.hr1, ic.hr0, ic.min1, ic.min0, ic.sec1, ic.sec0};

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    {ia.start_resume, ia.stop, ia.set_time, ia.in_pm} = '0;
    {ib.start_resume, ib.stop, ib.set_time, ib.in_pm} = '0;
    {ic.start_resume, ic.stop, ic.set_time, ic.in_pm} = '0;
    {ia.in_hr1, ia.in_hr0, ia.in_min1, ia.in_min0, ia.in_sec1, ia.in_sec0} = '0;
    {ib.in_hr1, ib.in_hr0, ib.in_min1, ib.in_min0, ib.in_sec1, ib.in_sec0} = '0;
    {ic.in_hr1, ic.in_hr0, ic.in_min1, ic.in_min0, ic.in_sec1, ic.in_sec0} = '0;

    // reset state
    step(2);
    chk("rst_a_time", t_a, 24'h000000);
    chk("rst_a_run", 24'(ia.running), 24'd0);
    chk("rst_a_dp", 24'(ia.daypass), 24'd0);
    chk("rst_a_err", 24'(ia.set_err), 24'd0);
    chk("rst_c_time", t_c, 24'h120000);
    chk("rst_c_pm", 24'(ic.pm), 24'd0);
    reset = 1'b1;

    // prescaler latency, stop/resume keeps partial second (CLK_DIV=4)
    ia.start_resume = 1'b1;
    step(1);
    ia.start_resume = 1'b0;
    chk("a_run_up", 24'(ia.running), 24'd1);
    step(3);
    chk("a_edge3", t_a, 24'h000000);
    step(1);
    chk("a_edge4", t_a, 24'h000001);
    step(1);
    ia.stop = 1'b1;
    step(1);
    ia.stop = 1'b0;
    chk("a_stopped", 24'(ia.running), 24'd0);
    step(3);
    chk("a_hold", t_a, 24'h000001);
    ia.start_resume = 1'b1;
    step(1);
    ia.start_resume = 1'b0;
    chk("a_resume0", t_a, 24'h000001);
    step(1);
    chk("a_resume1", t_a, 24'h000001);
    step(1);
    chk("a_resume2", t_a, 24'h000002);
    ia.start_resume = 1'b1;
    ia.stop = 1'b1;
    step(1);
    ia.start_resume = 1'b0;
    ia.stop = 1'b0;
    chk("a_both_stop", 24'(ia.running), 24'd0);

    // 24h rollover with CLK_DIV=1
    {ib.in_hr1, ib.in_hr0, ib.in_min1, ib.in_min0, ib.in_sec1, ib.in_sec0} = 24'h235958;
    ib.set_time = 1'b1;
    step(1);
    ib.set_time = 1'b0;
    chk("b_load", t_b, 24'h235958);
    ib.start_resume = 1'b1;
    step(1);
    ib.start_resume = 1'b0;
    chk("b_run_noadv", t_b, 24'h235958);
    step(1);
    chk("b_59", t_b, 24'h235959);
    chk("b_59_dp", 24'(ib.daypass), 24'd0);
    step(1);
    chk("b_wrap", t_b, 24'h000000);
    chk("b_wrap_dp", 24'(ib.daypass), 24'd1);
    step(1);
    chk("b_01", t_b, 24'h000001);
    chk("b_01_dp", 24'(ib.daypass), 24'd0);
    ib.stop = 1'b1;
    step(1);
    ib.stop = 1'b0;
    chk("b_stop_adv", t_b, 24'h000002);

    // invalid loads, 24h
    {ib.in_hr1, ib.in_hr0, ib.in_min1, ib.in_min0, ib.in_sec1, ib.in_sec0} = 24'h120660;
    ib.set_time = 1'b1;
    step(1);
    chk("b_bad_sec1", t_b, 24'h000002);
    chk("b_bad_sec1_err", 24'(ib.set_err), 24'd1);
    {ib.in_hr1, ib.in_hr0, ib.in_min1, ib.in_min0, ib.in_sec1, ib.in_sec0} = 24'h240000;
    step(1);
    chk("b_bad_hr24", t_b, 24'h000002);
    chk("b_bad_hr24_err", 24'(ib.set_err), 24'd1);
    {ib.in_hr1, ib.in_hr0, ib.in_min1, ib.in_min0, ib.in_sec1, ib.in_sec0} = 24'h100A00;
    step(1);
    chk("b_bad_min0", t_b, 24'h000002);
    chk("b_bad_min0_err", 24'(ib.set_err), 24'd1);
    {ib.in_hr1, ib.in_hr0, ib.in_min1, ib.in_min0, ib.in_sec1, ib.in_sec0} = 24'h134530;
    step(1);
    ib.set_time = 1'b0;
    chk("b_good", t_b, 24'h134530);
    chk("b_good_err", 24'(ib.set_err), 24'd0);

    // invalid loads, 12h
    {ic.in_hr1, ic.in_hr0, ic.in_min1, ic.in_min0, ic.in_sec1, ic.in_sec0} = 24'h001000;
    ic.set_time = 1'b1;
    step(1);
    chk("c_bad_hr00", t_c, 24'h120000);
    chk("c_bad_hr00_err", 24'(ic.set_err), 24'd1);
    {ic.in_hr1, ic.in_hr0, ic.in_min1, ic.in_min0, ic.in_sec1, ic.in_sec0} = 24'h131000;
    step(1);
    chk("c_bad_hr13", t_c, 24'h120000);
    chk("c_bad_hr13_err", 24'(ic.set_err), 24'd1);

    // 12h transitions
    {ic.in_hr1, ic.in_hr0, ic.in_min1, ic.in_min0, ic.in_sec1, ic.in_sec0} = 24'h115959;
    ic.in_pm = 1'b0;
    step(1);
    ic.set_time = 1'b0;
    chk("c_load_am", t_c, 24'h115959);
    chk("c_load_am_err", 24'(ic.set_err), 24'd0);
    ic.start_resume = 1'b1;
    step(1);
    ic.start_resume = 1'b0;
    step(1);
    chk("c_noon", t_c, 24'h120000);
    chk("c_noon_pm", 24'(ic.pm), 24'd1);
    chk("c_noon_dp", 24'(ic.daypass), 24'd0);
    {ic.in_hr1, ic.in_hr0, ic.in_min1, ic.in_min0, ic.in_sec1, ic.in_sec0} = 24'h125959;
    ic.in_pm = 1'b1;
    ic.set_time = 1'b1;
    step(1);
    ic.set_time = 1'b0;
    chk("c_load_12pm", t_c, 24'h125959);
    step(1);
    chk("c_one", t_c, 24'h010000);
    chk("c_one_pm", 24'(ic.pm), 24'd1);
    chk("c_one_dp", 24'(ic.daypass), 24'd0);
    {ic.in_hr1, ic.in_hr0, ic.in_min1, ic.in_min0, ic.in_sec1, ic.in_sec0} = 24'h115959;
    ic.set_time = 1'b1;
    step(1);
    ic.set_time = 1'b0;
    chk("c_load_11pm", t_c, 24'h115959);
    step(1);
    chk("c_midnight", t_c, 24'h120000);
    chk("c_midnight_pm", 24'(ic.pm), 24'd0);
    chk("c_midnight_dp", 24'(ic.daypass), 24'd1);
    step(1);
    chk("c_after", t_c, 24'h120001);
    chk("c_after_dp", 24'(ic.daypass), 24'd0);

    // load coincident with a rollover tick (CLK_DIV=4)
    {ia.in_hr1, ia.in_hr0, ia.in_min1, ia.in_min0, ia.in_sec1, ia.in_sec0} = 24'h235959;
    ia.set_time = 1'b1;
    step(1);
    ia.set_time = 1'b0;
    ia.start_resume = 1'b1;
    step(1);
    ia.start_resume = 1'b0;
    step(3);
    chk("a_pre_roll", t_a, 24'h235959);
    {ia.in_hr1, ia.in_hr0, ia.in_min1, ia.in_min0, ia.in_sec1, ia.in_sec0} = 24'h081500;
    ia.set_time = 1'b1;
    step(1);
    ia.set_time = 1'b0;
    chk("a_coinc_load", t_a, 24'h081500);
    chk("a_coinc_dp", 24'(ia.daypass), 24'd0);
    step(3);
    chk("a_restart3", t_a, 24'h081500);
    step(1);
    chk("a_restart4", t_a, 24'h081501);

    // invalid load while running, then reset mid-count
    {ia.in_hr1, ia.in_hr0, ia.in_min1, ia.in_min0, ia.in_sec1, ia.in_sec0} = 24'h240000;
    ia.set_time = 1'b1;
    step(1);
    ia.set_time = 1'b0;
    chk("a_bad_run", t_a, 24'h081501);
    chk("a_bad_run_err", 24'(ia.set_err), 24'd1);
    reset = 1'b0;
    step(1);
    chk("a_mid_rst", t_a, 24'h000000);
    chk("a_mid_rst_run", 24'(ia.running), 24'd0);
    chk("a_mid_rst_err", 24'(ia.set_err), 24'd0);
    chk("c_mid_rst", t_c, 24'h120000);
    chk("c_mid_rst_pm", 24'(ic.pm), 24'd0);
    reset = 1'b1;
    ia.start_resume = 1'b1;
    step(1);
    ia.start_resume = 1'b0;
    step(3);
    chk("a_post_rst3", t_a, 24'h000000);
    step(1);
    chk("a_post_rst4", t_a, 24'h000001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
